// File: rtl/ne_generation_sequencer.sv
// ne_generation_sequencer: runs the evaluate/select/mutate workers one at a time over the population and generations
module ne_generation_sequencer #(
  parameter int POP_SIZE = 16,
  parameter int IDX_W = 4,
  parameter int NUM_GEN = 100,
  parameter int GEN_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  output logic             eval_start,
  input  logic             eval_done,
  output logic             sel_start,
  input  logic             sel_done,
  output logic             mut_start,
  input  logic             mut_done,
  output logic [IDX_W-1:0] genome_idx,
  output logic [GEN_W-1:0] generation,
  output logic             busy,
  output logic             finished
);
  typedef enum logic [2:0] {IDLE, EVAL_GO, EVAL_WAIT, SEL_GO, SEL_WAIT, MUT_GO, MUT_WAIT, DONE} state_t;
  localparam logic [IDX_W-1:0] last_idx = IDX_W'(POP_SIZE - 1);
  localparam logic [GEN_W-1:0] last_gen = GEN_W'(NUM_GEN - 1);
  state_t state, state_next;
  logic [IDX_W-1:0] idx_next;
  logic [GEN_W-1:0] gen_next;
  // next state and counter values; abort overrides every transition and freezes the counters
  always_comb begin
    state_next = state;
    idx_next = genome_idx;
    gen_next = generation;
    case (state)
      IDLE, DONE: if (start) begin
        state_next = EVAL_GO;
        idx_next = '0;
        gen_next = '0;
      end
      EVAL_GO: state_next = EVAL_WAIT;
      EVAL_WAIT: if (eval_done) begin
        state_next = (genome_idx < last_idx) ? EVAL_GO : SEL_GO;
        idx_next = (genome_idx < last_idx) ? genome_idx + IDX_W'(1) : genome_idx;
      end
      SEL_GO: state_next = SEL_WAIT;
      SEL_WAIT: if (sel_done) state_next = MUT_GO;
      MUT_GO: state_next = MUT_WAIT;
      MUT_WAIT: if (mut_done) begin
        state_next = (generation == last_gen) ? DONE : EVAL_GO;
        gen_next = (generation == last_gen) ? generation : generation + GEN_W'(1);
        idx_next = (generation == last_gen) ? genome_idx : '0;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      idx_next = genome_idx;
      gen_next = generation;
    end
  end
  // state and counter registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      genome_idx <= '0;
      generation <= '0;
    end else begin
      state <= state_next;
      genome_idx <= idx_next;
      generation <= gen_next;
    end
  end
  assign eval_start = state == EVAL_GO;
  assign sel_start = state == SEL_GO;
  assign mut_start = state == MUT_GO;
  assign finished = state == DONE;
  assign busy = state != IDLE && state != DONE;
endmodule

// File: tb/tb_ne_generation_sequencer.sv
// tb_ne_generation_sequencer: scoreboard bench for the generation sequencer
module tb_ne_generation_sequencer;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic one = 1'b1;
  always #5 clock = ~clock;
  logic a_start = 1'b0, a_abort = 1'b0, a_es, a_ss, a_ms, a_busy, a_fin;
  logic [3:0] a_idx;
  logic [7:0] a_gen;
  logic b_start = 1'b0, b_abort = 1'b0, b_ed = 1'b0, b_sd = 1'b0, b_md = 1'b0;
  logic b_es, b_ss, b_ms, b_busy, b_fin;
  logic [3:0] b_idx;
  logic [7:0] b_gen;
  int errors = 0, checks = 0;
  int n_ev = 0, n_sel = 0, n_mut = 0;
  int exp_ev = 0, exp_sel = 0, exp_mut = 0;
  logic [13:0] sb[$];

  ne_generation_sequencer #(.POP_SIZE(2), .IDX_W(4), .NUM_GEN(1), .GEN_W(8)) u_a (
    .clock(clock), .resetn(resetn), .start(a_start), .abort(a_abort),
    .eval_start(a_es), .eval_done(one), .sel_start(a_ss), .sel_done(one),
    .mut_start(a_ms), .mut_done(one), .genome_idx(a_idx), .generation(a_gen),
    .busy(a_busy), .finished(a_fin));

  ne_generation_sequencer #(.POP_SIZE(4), .IDX_W(4), .NUM_GEN(3), .GEN_W(8)) u_b (
    .clock(clock), .resetn(resetn), .start(b_start), .abort(b_abort),
    .eval_start(b_es), .eval_done(b_ed), .sel_start(b_ss), .sel_done(b_sd),
    .mut_start(b_ms), .mut_done(b_md), .genome_idx(b_idx), .generation(b_gen),
    .busy(b_busy), .finished(b_fin));

  // count every start pulse the second instance emits
  always @(negedge clock) begin
    if (b_es) n_ev++;
    if (b_ss) n_sel++;
    if (b_ms) n_mut++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_gen(input int g);
    for (int i = 0; i < 4; i++) begin
      sb.push_back({2'd1, 8'(g), 4'(i)});
      exp_ev++;
    end
    sb.push_back({2'd2, 8'(g), 4'd3});
    sb.push_back({2'd3, 8'(g), 4'd3});
    exp_sel++;
    exp_mut++;
  endtask

  task automatic catch_pulse(output logic [1:0] kind);
    int t;
    t = 0;
    kind = 2'd0;
    while (kind == 2'd0 && t < 40) begin
      @(negedge clock);
      t++;
      kind = b_es ? 2'd1 : b_ss ? 2'd2 : b_ms ? 2'd3 : 2'd0;
    end
    if (kind == 2'd0) check("pulse_timeout", 32'd0, 32'd1);
    else if (sb.size() == 0) check("unexpected_pulse", {kind, b_gen, b_idx}, 32'd0);
    else check("pulse", {kind, b_gen, b_idx}, sb.pop_front());
  endtask

  task automatic answer(input logic [1:0] kind, input int d);
    repeat (d) @(posedge clock);
    #1;
    b_ed = kind == 2'd1;
    b_sd = kind == 2'd2;
    b_md = kind == 2'd3;
    @(posedge clock);
    #1;
    b_ed = 1'b0;
    b_sd = 1'b0;
    b_md = 1'b0;
  endtask

  task automatic serve(input int n, input int d);
    logic [1:0] k;
    for (int j = 0; j < n; j++) begin
      catch_pulse(k);
      if (k != 2'd0) answer(k, d);
    end
  endtask

  task automatic b_go();
    b_start = 1'b1;
    @(posedge clock);
    #1;
    b_start = 1'b0;
  endtask

  initial begin
    logic [1:0] k;
    int s_ev, s_sel, s_mut;
    repeat (3) @(posedge clock);
    #1;
    check("a_reset", {a_es, a_ss, a_ms, a_busy, a_fin, a_gen, a_idx}, 32'd0);
    check("b_reset", {b_es, b_ss, b_ms, b_busy, b_fin, b_gen, b_idx}, 32'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    a_start = 1'b1;
    @(posedge clock);
    #1;
    a_start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("t1_c%0d", c), {a_es, a_ss, a_ms, a_busy, a_fin, a_gen, a_idx},
            {c == 1 || c == 3, c == 5, c == 7, c < 9, c >= 9, 8'd0, 4'(c >= 3)});
      @(posedge clock);
      #1;
    end
    a_start = 1'b1;
    a_abort = 1'b1;
    @(posedge clock);
    #1;
    a_start = 1'b0;
    a_abort = 1'b0;
    check("t6_abort_beats_start", {a_es, a_busy, a_fin}, 32'd0);
    @(posedge clock);
    #1;
    check("t6_no_eval", {a_es, a_busy, a_fin}, 32'd0);
    for (int g = 0; g < 3; g++) push_gen(g);
    b_go();
    serve(18, 5);
    check("t2_done", {b_busy, b_fin, b_gen, b_idx}, {1'b0, 1'b1, 8'd2, 4'd3});
    repeat (5) @(posedge clock);
    #1;
    check("t2_hold", {b_busy, b_fin, b_gen}, {1'b0, 1'b1, 8'd2});
    check("t2_ev_count", n_ev, 12);
    check("t2_sel_count", n_sel, 3);
    check("t2_mut_count", n_mut, 3);
    push_gen(0);
    b_go();
    check("t2_fin_cleared", {b_busy, b_fin, b_gen, b_idx}, {1'b1, 1'b0, 8'd0, 4'd0});
    b_ed = 1'b1;
    catch_pulse(k);
    @(posedge clock);
    #1;
    b_ed = 1'b0;
    b_sd = 1'b1;
    b_md = 1'b1;
    s_ev = n_ev;
    s_sel = n_sel;
    s_mut = n_mut;
    repeat (3) @(posedge clock);
    #1;
    b_sd = 1'b0;
    b_md = 1'b0;
    check("t3_ignored", {b_busy, b_es, b_ss, b_ms, b_idx}, {1'b1, 3'd0, 4'd0});
    check("t3_no_pulses", {n_ev - s_ev, n_sel - s_sel, n_mut - s_mut}, 32'd0);
    answer(2'd1, 0);
    serve(3, 1);
    catch_pulse(k);
    @(posedge clock);
    #1;
    s_ev = n_ev;
    b_start = 1'b1;
    @(posedge clock);
    #1;
    b_start = 1'b0;
    check("t4_start_ignored", {b_busy, b_es, b_idx, b_gen}, {1'b1, 1'b0, 4'd3, 8'd0});
    check("t4_no_eval", n_ev - s_ev, 32'd0);
    answer(2'd2, 0);
    catch_pulse(k);
    @(posedge clock);
    #1;
    b_abort = 1'b1;
    b_md = 1'b1;
    @(posedge clock);
    #1;
    b_abort = 1'b0;
    b_md = 1'b0;
    check("t4_abort", {b_busy, b_fin, b_gen, b_idx}, {1'b0, 1'b0, 8'd0, 4'd3});
    push_gen(0);
    push_gen(1);
    b_go();
    serve(6, 1);
    serve(5, 1);
    catch_pulse(k);
    @(posedge clock);
    #1;
    check("t5_gen1", {b_busy, b_gen}, {1'b1, 8'd1});
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    check("t5_reset", {b_es, b_ss, b_ms, b_busy, b_fin, b_gen, b_idx}, 32'd0);
    sb.push_back({2'd1, 8'd0, 4'd0});
    exp_ev++;
    b_go();
    catch_pulse(k);
    @(posedge clock);
    #1;
    b_abort = 1'b1;
    @(posedge clock);
    #1;
    b_abort = 1'b0;
    check("t5_abort_idle", {b_busy, b_fin, b_gen, b_idx}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("ev_count", n_ev, exp_ev);
    check("sel_count", n_sel, exp_sel);
    check("mut_count", n_mut, exp_mut);
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
